// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// One transaction at a time: IDLE (arbitrate/latch) -> SERVE (memory access) -> DONE (ack).
module dmem_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic [31:0] rdata0_o,
  output logic [31:0] rdata1_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic        oor_q, oor_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        winner;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        serve_ok;
  logic        done_ok;

  // On a tie the port that was not granted last wins.
  always_comb begin
    winner = 1'b0;
    if (req0_i && req1_i) begin
      winner = ~last_grant_q;
    end else if (req1_i) begin
      winner = 1'b1;
    end
    sel_we    = winner ? we1_i    : we0_i;
    sel_addr  = winner ? addr1_i  : addr0_i;
    sel_wdata = winner ? wdata1_i : wdata0_i;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    oor_d        = oor_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          gnt_d        = winner;
          last_grant_d = winner;
          we_d         = sel_we;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          oor_d        = (sel_addr >= ADDR_LIMIT);
          state_d      = SERVE;
        end
      end
      SERVE: begin
        state_d = DONE;
        if (!we_q && !oor_q) begin
          if (gnt_q) rdata1_d = mem_rdata_i;
          else       rdata0_d = mem_rdata_i;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      oor_q        <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rdata0_q     <= 32'h0;
      rdata1_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      oor_q        <= oor_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Reset gates the strobes so an aborted write never reaches memory and no ack escapes.
  assign serve_ok    = (state_q == SERVE) && !oor_q && !reset_i;
  assign done_ok     = (state_q == DONE) && !reset_i;
  assign mem_read_o  = serve_ok && !we_q;
  assign mem_write_o = serve_ok && we_q;
  assign mem_addr_o  = serve_ok ? addr_q : 32'h0;
  assign mem_wdata_o = (serve_ok && we_q) ? wdata_q : 32'h0;

  assign ack0_o   = done_ok && !gnt_q;
  assign ack1_o   = done_ok && gnt_q;
  assign err0_o   = ack0_o && oor_q;
  assign err1_o   = ack1_o && oor_q;
  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;

endmodule
